// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port integer register file with a per-register
// busy scoreboard for RAW hazard detection in the pipelined core.

// One read port: x0 forcing and optional same-cycle writeback forwarding.
module regfile_scoreboard_rdport #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int BYPASS     = 1
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] reg_data,
    input  logic                  reg_busy,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  busy
);
    logic fwd;
    assign fwd = (BYPASS != 0) && wb_valid && (wb_addr == addr);

    // x0 is constant zero; a forwarded writeback shows its data, and busy only
    // if an issue to the same register lands on the same edge.
    always_comb begin
        data = reg_data;
        busy = reg_busy;
        if (addr == '0) begin
            data = '0;
            busy = 1'b0;
        end else if (fwd) begin
            data = wb_data;
            busy = issue_valid && (issue_addr == addr);
        end
    end
endmodule

module regfile_scoreboard #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data_o,
    output logic [NUM_RD-1:0]            rd_busy_o,
    input  logic                         issue_valid_i,
    input  logic [ADDR_WIDTH-1:0]        issue_addr_i,
    input  logic                         wb_valid_i,
    input  logic [ADDR_WIDTH-1:0]        wb_addr_i,
    input  logic [DATA_WIDTH-1:0]        wb_data_i,
    input  logic                         flush_i,
    output logic [2**ADDR_WIDTH-1:0]     busy_vec_o,
    output logic [ADDR_WIDTH:0]          pending_cnt_o
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy_q, busy_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    // Register storage; writes to x0 are dropped so regs[0] stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wb_valid_i && (wb_addr_i != '0)) begin
            regs[wb_addr_i] <= wb_data_i;
        end
    end

    // Next busy vector: flush, then wb clear, then issue set (issue wins).
    // The count is a full popcount of the next vector, so it cannot drift.
    always_comb begin
        busy_d = busy_q;
        if (flush_i)       busy_d = '0;
        if (wb_valid_i)    busy_d[wb_addr_i] = 1'b0;
        if (issue_valid_i) busy_d[issue_addr_i] = 1'b1;
        busy_d[0] = 1'b0;
        cnt_d = '0;
        for (int i = 1; i < DEPTH; i++) cnt_d = cnt_d + CW'(busy_d[i]);
    end

    // Scoreboard state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_vec_o    = busy_q;
    assign pending_cnt_o = cnt_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] a;
        assign a = rd_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        regfile_scoreboard_rdport #(
            .ADDR_WIDTH(ADDR_WIDTH),
            .DATA_WIDTH(DATA_WIDTH),
            .BYPASS    (BYPASS)
        ) u_rd (
            .addr       (a),
            .reg_data   (regs[a]),
            .reg_busy   (busy_q[a]),
            .wb_valid   (wb_valid_i),
            .wb_addr    (wb_addr_i),
            .wb_data    (wb_data_i),
            .issue_valid(issue_valid_i),
            .issue_addr (issue_addr_i),
            .data       (rd_data_o[k*DATA_WIDTH +: DATA_WIDTH]),
            .busy       (rd_busy_o[k])
        );
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a BYPASS=1 and a BYPASS=0 instance share all
// inputs; expected reads and next-state values come from a reference model.
module tb_regfile_scoreboard;
    localparam int AW = 5, DW = 32, NR = 2, DEPTH = 32;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR*DW-1:0] rd_data_b, rd_data_n;
    logic [NR-1:0]    rd_busy_b, rd_busy_n;
    logic             issue_valid = 1'b0, wb_valid = 1'b0, flush = 1'b0;
    logic [AW-1:0]    issue_addr = '0, wb_addr = '0;
    logic [DW-1:0]    wb_data = '0;
    logic [DEPTH-1:0] vec_b, vec_n;
    logic [AW:0]      cnt_b, cnt_n;

    int checks = 0, failures = 0;

    regfile_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .BYPASS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b), .rd_busy_o(rd_busy_b),
        .issue_valid_i(issue_valid), .issue_addr_i(issue_addr), .wb_valid_i(wb_valid),
        .wb_addr_i(wb_addr), .wb_data_i(wb_data), .flush_i(flush),
        .busy_vec_o(vec_b), .pending_cnt_o(cnt_b));

    regfile_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .BYPASS(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_n), .rd_busy_o(rd_busy_n),
        .issue_valid_i(issue_valid), .issue_addr_i(issue_addr), .wb_valid_i(wb_valid),
        .wb_addr_i(wb_addr), .wb_data_i(wb_data), .flush_i(flush),
        .busy_vec_o(vec_n), .pending_cnt_o(cnt_n));

    always #5 clk = ~clk;

    // Reference model
    logic [DW-1:0]    m_regs [DEPTH];
    logic [DEPTH-1:0] m_busy;

    typedef struct { logic [DW-1:0] data; logic busy; } rd_exp_t;
    typedef struct { logic [DEPTH-1:0] vec; logic [AW:0] cnt; } st_exp_t;
    typedef struct { bit iv; logic [AW-1:0] ia; bit wv; logic [AW-1:0] wa; logic [DW-1:0] wd;
                     bit fl; logic [AW-1:0] r0; logic [AW-1:0] r1; } row_t;

    rd_exp_t rq[$];
    st_exp_t sq[$];

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
        m_busy = '0;
    endfunction

    function automatic rd_exp_t pred(bit byp, logic [AW-1:0] a);
        rd_exp_t e;
        if (a == 0) begin e.data = '0; e.busy = 1'b0; end
        else if (byp && wb_valid && wb_addr == a) begin
            e.data = wb_data; e.busy = issue_valid && (issue_addr == a);
        end else begin e.data = m_regs[a]; e.busy = m_busy[a]; end
        return e;
    endfunction

    // Drive one stimulus row and queue the expected same-cycle reads.
    task automatic drive_row(input row_t r);
        issue_valid = r.iv; issue_addr = r.ia;
        wb_valid = r.wv; wb_addr = r.wa; wb_data = r.wd;
        flush = r.fl; rd_addr = {r.r1, r.r0};
        #1;
        rq.push_back(pred(1'b1, r.r0)); rq.push_back(pred(1'b0, r.r0));
        rq.push_back(pred(1'b1, r.r1)); rq.push_back(pred(1'b0, r.r1));
    endtask

    // Advance the model with the current inputs, queue the expected state,
    // then take the clock edge and return to the negedge.
    task automatic tick();
        logic [DEPTH-1:0] nb;
        st_exp_t s;
        if (wb_valid && wb_addr != 0) m_regs[wb_addr] = wb_data;
        nb = m_busy;
        if (flush) nb = '0;
        if (wb_valid) nb[wb_addr] = 1'b0;
        if (issue_valid) nb[issue_addr] = 1'b1;
        nb[0] = 1'b0;
        m_busy = nb;
        s.vec = m_busy; s.cnt = (AW+1)'($countones(m_busy));
        sq.push_back(s);
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset();
        row_t r;
        st_exp_t s;
        r = '{1'b1, 5'd6, 1'b1, 5'd5, 32'hA5A5_0001, 1'b0, 5'd5, 5'd6};
        drive_row(r);
        rq.delete();
        tick();
        s = sq.pop_front(); checks++;
        if (vec_b !== s.vec || cnt_b !== s.cnt) begin
            failures++; $display("FAIL reset_pre: vec=%h cnt=%0d want vec=%h cnt=%0d", vec_b, cnt_b, s.vec, s.cnt);
        end
        issue_valid = 0; wb_valid = 0; rd_addr = {5'd6, 5'd5};
        #2 rst_n = 1'b0;   // mid-cycle, no clock edge
        #1;
        model_clear();
        for (int k = 0; k < NR; k++) begin
            checks++;
            if (rd_data_b[k*DW +: DW] !== '0 || rd_data_n[k*DW +: DW] !== '0 || rd_busy_b[k] !== 1'b0 || rd_busy_n[k] !== 1'b0) begin
                failures++; $display("FAIL reset_rd p%0d: got %h/%h busy %b/%b want 0", k, rd_data_b[k*DW +: DW], rd_data_n[k*DW +: DW], rd_busy_b[k], rd_busy_n[k]);
            end
        end
        checks++;
        if (vec_b !== '0 || vec_n !== '0 || cnt_b !== '0 || cnt_n !== '0) begin
            failures++; $display("FAIL reset_state: vec=%h/%h cnt=%0d/%0d want 0", vec_b, vec_n, cnt_b, cnt_n);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Run a table of rows: compare reads before the edge, state after it.
    task automatic run_rows(input string tag, input row_t rows[$]);
        rd_exp_t e;
        st_exp_t s;
        foreach (rows[i]) begin
            drive_row(rows[i]);
            for (int k = 0; k < NR; k++) begin
                e = rq.pop_front(); checks++;
                if ({rd_busy_b[k], rd_data_b[k*DW +: DW]} !== {e.busy, e.data}) begin
                    failures++; $display("FAIL %s row%0d byp p%0d: got %b/%h want %b/%h", tag, i, k, rd_busy_b[k], rd_data_b[k*DW +: DW], e.busy, e.data);
                end
                e = rq.pop_front(); checks++;
                if ({rd_busy_n[k], rd_data_n[k*DW +: DW]} !== {e.busy, e.data}) begin
                    failures++; $display("FAIL %s row%0d nobyp p%0d: got %b/%h want %b/%h", tag, i, k, rd_busy_n[k], rd_data_n[k*DW +: DW], e.busy, e.data);
                end
            end
            tick();
            s = sq.pop_front(); checks++;
            if (vec_b !== s.vec || vec_n !== s.vec || cnt_b !== s.cnt || cnt_n !== s.cnt || vec_b[0] !== 1'b0) begin
                failures++; $display("FAIL %s row%0d state: vec=%h/%h cnt=%0d/%0d want vec=%h cnt=%0d", tag, i, vec_b, vec_n, cnt_b, cnt_n, s.vec, s.cnt);
            end
        end
    endtask

    task automatic test_write_read();
        row_t rows[$];
        rows = '{'{0, 0, 1, 5'd5, 32'hDEAD_BEEF, 0, 5'd5, 5'd5},
                 '{0, 0, 0, 0, 0, 0, 5'd5, 5'd5},
                 '{0, 0, 1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0, 5'd5},
                 '{0, 0, 0, 0, 0, 0, 5'd0, 5'd0}};
        run_rows("write_read", rows);
        checks++;
        if (rd_data_b[DW-1:0] !== '0 || rd_data_n[DW-1:0] !== '0) begin
            failures++; $display("FAIL x0_read: got %h/%h want 0", rd_data_b[DW-1:0], rd_data_n[DW-1:0]);
        end
    endtask

    task automatic test_bypass();
        row_t rows[$];
        rows = '{'{0, 0, 1, 5'd7, 32'h0000_1111, 0, 5'd1, 5'd2},
                 '{0, 0, 1, 5'd7, 32'h0000_1234, 0, 5'd7, 5'd3},
                 '{0, 0, 0, 0, 0, 0, 5'd7, 5'd7},
                 '{1, 5'd7, 1, 5'd7, 32'h0000_7777, 0, 5'd7, 5'd8},
                 '{0, 0, 0, 0, 0, 0, 5'd7, 5'd7}};
        run_rows("bypass", rows);
        checks++;
        if (rd_data_n[DW-1:0] !== 32'h0000_7777 || rd_busy_n[0] !== 1'b1) begin
            failures++; $display("FAIL bypass_after: got %h/%b want 00007777/1", rd_data_n[DW-1:0], rd_busy_n[0]);
        end
        rows = '{'{0, 0, 1, 5'd7, 0, 0, 5'd7, 5'd7}};
        run_rows("bypass_clr", rows);
    endtask

    task automatic test_scoreboard();
        row_t rows[$];
        rows = '{'{1, 5'd3, 0, 0, 0, 0, 5'd3, 5'd4},
                 '{1, 5'd4, 0, 0, 0, 0, 5'd3, 5'd4},
                 '{1, 5'd3, 0, 0, 0, 0, 5'd3, 5'd4},
                 '{0, 0, 1, 5'd3, 32'h33, 0, 5'd3, 5'd4},
                 '{1, 5'd0, 1, 5'd10, 32'hAA, 0, 5'd3, 5'd0},
                 '{0, 0, 0, 0, 0, 0, 5'd3, 5'd10}};
        run_rows("scoreboard", rows);
        checks++;
        if (vec_b !== 32'h0000_0010 || cnt_b !== 6'd1 || rd_busy_b[0] !== 1'b0) begin
            failures++; $display("FAIL sb_final: vec=%h cnt=%0d busy3=%b want 00000010/1/0", vec_b, cnt_b, rd_busy_b[0]);
        end
    endtask

    task automatic test_simultaneous();
        row_t rows[$];
        rows = '{'{1, 5'd9, 1, 5'd9, 32'h55, 0, 5'd9, 5'd4},
                 '{0, 0, 0, 0, 0, 0, 5'd9, 5'd9},
                 '{1, 5'd2, 0, 0, 0, 1, 5'd9, 5'd2},
                 '{0, 0, 0, 0, 0, 0, 5'd9, 5'd2}};
        run_rows("simultaneous", rows);
        checks++;
        if (vec_b !== 32'h0000_0004 || cnt_b !== 6'd1 || rd_data_b[DW-1:0] !== 32'h55) begin
            failures++; $display("FAIL flush_issue: vec=%h cnt=%0d x9=%h want 00000004/1/55", vec_b, cnt_b, rd_data_b[DW-1:0]);
        end
    endtask

    task automatic test_random();
        row_t rows[$];
        row_t r;
        for (int n = 0; n < 10000; n++) begin
            r.iv = ($urandom_range(0, 2) != 0);
            r.ia = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            r.wv = ($urandom_range(0, 2) != 0);
            r.wa = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            r.wd = $urandom;
            r.fl = ($urandom_range(0, 40) == 0);
            r.r0 = ($urandom_range(0, 1) != 0) ? r.wa : AW'($urandom);
            r.r1 = AW'($urandom_range(0, 7));
            rows.push_back(r);
        end
        run_rows("random", rows);
    endtask

    initial begin
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_simultaneous();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
